// File: rtl/curve_lut_pipe.sv
// curve_lut_pipe: per-channel clamp, index and table lookup with optional linear interpolation,
// carried through a three-stage valid/ready pipeline that stalls as a whole.
module curve_lut_pipe #(
    parameter int WIDTH    = 16,
    parameter int CHANNELS = 3,
    parameter int DEPTH    = 256,
    parameter int SHIFT    = 2,
    parameter int CLAMP_HI = 1023,
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [1:0]                cfg_mode,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [CHANNELS*WIDTH-1:0] out_data,
    input  logic                      cfg_wen,
    input  logic [CW-1:0]             cfg_chan,
    input  logic [AW-1:0]             cfg_addr,
    input  logic [WIDTH-1:0]          cfg_wdata
);
    localparam logic signed [WIDTH-1:0] HI   = WIDTH'(CLAMP_HI);
    localparam logic [WIDTH-1:0]        LAST = WIDTH'(DEPTH - 1);
    localparam int                      PW   = WIDTH + SHIFT + 2;

    logic             adv;
    logic [WIDTH-1:0] tab [CHANNELS][DEPTH];
    logic [WIDTH-1:0] xc [CHANNELS];
    logic [AW-1:0]    i0 [CHANNELS];
    logic [AW-1:0]    i1 [CHANNELS];
    logic [WIDTH-1:0] res [CHANNELS];
    logic             s0_valid, s1_valid;
    logic [1:0]       s0_mode, s1_mode;
    logic [WIDTH-1:0] s0_xc [CHANNELS];
    logic [AW-1:0]    s0_i0 [CHANNELS];
    logic [AW-1:0]    s0_i1 [CHANNELS];
    logic [SHIFT-1:0] s0_frac [CHANNELS];
    logic [WIDTH-1:0] s1_xc [CHANNELS];
    logic [WIDTH-1:0] s1_t0 [CHANNELS];
    logic [WIDTH-1:0] s1_t1 [CHANNELS];
    logic [SHIFT-1:0] s1_frac [CHANNELS];

    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    for (genvar g = 0; g < CHANNELS; g++) begin : ch
        logic signed [WIDTH-1:0] xs;
        logic [WIDTH-1:0]        idx;
        logic signed [PW-1:0]    dif;
        logic [WIDTH-1:0]        step;
        assign xs     = $signed(in_data[g*WIDTH +: WIDTH]);
        assign xc[g]  = xs[WIDTH-1] ? '0 : (xs > HI ? HI : xs);
        assign idx    = xc[g] >> SHIFT;
        assign i0[g]  = (idx >= LAST) ? AW'(DEPTH - 1) : idx[AW-1:0];
        assign i1[g]  = (idx >= LAST) ? AW'(DEPTH - 1) : idx[AW-1:0] + 1'b1;
        // Signed slope times fraction, floored by the arithmetic shift, wraps into WIDTH bits.
        assign dif    = PW'($signed({1'b0, s1_t1[g]}) - $signed({1'b0, s1_t0[g]}));
        assign step   = WIDTH'((dif * $signed(PW'({1'b0, s1_frac[g]}))) >>> SHIFT);
        assign res[g] = (s1_mode == 2'd0) ? s1_xc[g] :
                        (s1_mode == 2'd2) ? s1_t0[g] + step : s1_t0[g];
    end

    always_ff @(posedge clk) begin
        if (cfg_wen && 32'(cfg_chan) < CHANNELS && 32'(cfg_addr) < DEPTH)
            tab[cfg_chan][cfg_addr] <= cfg_wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s0_valid  <= 1'b0;
            s1_valid  <= 1'b0;
            out_valid <= 1'b0;
            s0_mode   <= '0;
            s1_mode   <= '0;
            out_data  <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                s0_xc[i]   <= '0;
                s0_i0[i]   <= '0;
                s0_i1[i]   <= '0;
                s0_frac[i] <= '0;
                s1_xc[i]   <= '0;
                s1_t0[i]   <= '0;
                s1_t1[i]   <= '0;
                s1_frac[i] <= '0;
            end
        end else if (adv) begin
            s0_valid  <= in_valid;
            s0_mode   <= cfg_mode;
            s1_valid  <= s0_valid;
            s1_mode   <= s0_mode;
            out_valid <= s1_valid;
            for (int i = 0; i < CHANNELS; i++) begin
                s0_xc[i]   <= xc[i];
                s0_i0[i]   <= i0[i];
                s0_i1[i]   <= i1[i];
                s0_frac[i] <= xc[i][SHIFT-1:0];
                s1_xc[i]   <= s0_xc[i];
                s1_t0[i]   <= tab[i][s0_i0[i]];
                s1_t1[i]   <= tab[i][s0_i1[i]];
                s1_frac[i] <= s0_frac[i];
                out_data[i*WIDTH +: WIDTH] <= res[i];
            end
        end
    end
endmodule

// File: tb/tb_curve_lut_pipe.sv
// tb_curve_lut_pipe: directed checks of curve_lut_pipe with hand-computed expectations.
module tb_curve_lut_pipe;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [47:0] in_data = '0;
    logic [1:0]  cfg_mode = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [47:0] out_data;
    logic        cfg_wen = 1'b0;
    logic [1:0]  cfg_chan = '0;
    logic [7:0]  cfg_addr = '0;
    logic [15:0] cfg_wdata = '0;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    curve_lut_pipe dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .cfg_mode(cfg_mode),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .cfg_wen(cfg_wen), .cfg_chan(cfg_chan), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata)
    );

    function automatic logic [47:0] pk(input int a, input int b, input int c);
        return {16'(c), 16'(b), 16'(a)};
    endfunction

    task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input int c, input int a, input int d);
        cfg_wen = 1'b1; cfg_chan = 2'(c); cfg_addr = 8'(a); cfg_wdata = 16'(d);
        @(negedge clk);
        cfg_wen = 1'b0;
    endtask

    task automatic beat(input logic [15:0] x, input logic [1:0] m);
        in_valid = 1'b1; in_data = {x, x, x}; cfg_mode = m;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic run1(input string tag, input logic [15:0] x, input logic [1:0] m, input logic [47:0] exp);
        beat(x, m);
        @(negedge clk);
        @(negedge clk);
        chk({tag, "_valid"}, 48'(out_valid), 48'(1));
        chk(tag, out_data, exp);
        @(negedge clk);
    endtask

    initial begin
        int sent, got, cyc, stall_left;
        logic stalled;
        logic [47:0] held;
        #2;
        chk("rst_out_valid", 48'(out_valid), 48'(0));
        chk("rst_out_data", out_data, 48'(0));
        chk("rst_in_ready", 48'(in_ready), 48'(1));
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int c = 0; c < 3; c++)
            for (int i = 0; i < 256; i++)
                wr(c, i, 4 * i + c);

        // Streaming, latency and one beat per cycle
        in_valid = 1'b1; cfg_mode = 2'd1; in_data = {3{16'd100}};
        @(negedge clk);
        chk("lat_e1", 48'(out_valid), 48'(0));
        in_data = {3{16'd101}};
        @(negedge clk);
        chk("lat_e2", 48'(out_valid), 48'(0));
        in_data = {3{16'd400}};
        @(negedge clk);
        chk("lat_e3", 48'(out_valid), 48'(1));
        chk("stream_100", out_data, pk(100, 101, 102));
        in_valid = 1'b0;
        @(negedge clk);
        chk("stream_101_valid", 48'(out_valid), 48'(1));
        chk("stream_101", out_data, pk(100, 101, 102));
        @(negedge clk);
        chk("stream_400", out_data, pk(400, 401, 402));
        @(negedge clk);
        chk("stream_drained", 48'(out_valid), 48'(0));

        // Clamp, saturation, bypass and mode 3
        run1("near_neg", 16'hFFFB, 2'd1, pk(0, 1, 2));
        run1("near_sat", 16'd2000, 2'd1, pk(1020, 1021, 1022));
        run1("byp_sat", 16'd2000, 2'd0, pk(1023, 1023, 1023));
        run1("byp_neg", 16'hFFFB, 2'd0, pk(0, 0, 0));
        run1("mode3", 16'd400, 2'd3, pk(400, 401, 402));

        // Interpolation, rising and falling slope, top-of-table
        wr(0, 10, 100);
        wr(0, 11, 140);
        run1("interp_up", 16'd42, 2'd2, pk(120, 43, 44));
        wr(0, 11, 60);
        run1("interp_down", 16'd43, 2'd2, pk(70, 44, 45));
        run1("interp_top", 16'd2000, 2'd2, pk(1020, 1021, 1022));

        // Backpressure: 6 beats, 5-cycle stall from first out_valid
        sent = 0; got = 0; cyc = 0; stall_left = 0; stalled = 1'b0; held = '0;
        while (got < 6 && cyc < 60) begin
            if (out_valid && !stalled) begin
                stalled = 1'b1; stall_left = 5; held = out_data;
            end
            out_ready = (stall_left == 0);
            if (stall_left > 0) stall_left--;
            in_valid = (sent < 6);
            cfg_mode = 2'd1;
            in_data = {3{16'(200 + 4 * sent)}};
            #1;
            if (!out_ready) begin
                chk("stall_in_ready", 48'(in_ready), 48'(0));
                chk("stall_hold", out_data, held);
            end
            if (in_valid && in_ready) sent++;
            if (out_valid && out_ready) begin
                chk("bp_order", out_data, pk(200 + 4 * got, 201 + 4 * got, 202 + 4 * got));
                got++;
            end
            @(negedge clk);
            cyc++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        chk("bp_count", 48'(got), 48'(6));
        @(negedge clk);
        chk("bp_no_dup", 48'(out_valid), 48'(0));

        // Write/read collision and out-of-range channel
        wr(1, 25, 7);
        in_valid = 1'b1; cfg_mode = 2'd1; in_data = {3{16'd100}};
        @(negedge clk);
        cfg_wen = 1'b1; cfg_chan = 2'd1; cfg_addr = 8'd25; cfg_wdata = 16'd9;
        @(negedge clk);
        cfg_wen = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("coll_old", out_data, pk(100, 7, 102));
        @(negedge clk);
        chk("coll_new", out_data, pk(100, 9, 102));
        @(negedge clk);
        wr(3, 25, 16'h5555);
        run1("chan3_ignored", 16'd100, 2'd1, pk(100, 9, 102));

        // Reset with three beats in flight
        in_valid = 1'b1; cfg_mode = 2'd1; in_data = {3{16'd100}};
        @(negedge clk);
        in_data = {3{16'd101}};
        @(negedge clk);
        in_data = {3{16'd400}};
        @(negedge clk);
        in_valid = 1'b0;
        chk("pre_rst_valid", 48'(out_valid), 48'(1));
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 48'(out_valid), 48'(0));
        chk("mid_rst_data", out_data, 48'(0));
        chk("mid_rst_ready", 48'(in_ready), 48'(1));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_empty", 48'(out_valid), 48'(0));
        run1("post_rst", 16'd400, 2'd1, pk(400, 401, 402));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
